// File: rtl/cache_writeback_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_writeback_buffer_pkg : shared widths and FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package cache_writeback_buffer_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_fifo : write-back entry FIFO with per-entry address-match vector
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_fifo
  import cache_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [MASK_W-1:0] push_mask,
  input  logic              pop,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [MASK_W-1:0] head_mask,
  output logic [DEPTH-1:0]  match,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [MASK_W-1:0] mask_mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
      mask_mem[wr_ptr] <= push_mask;
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign head_mask = mask_mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PTR_W-1:0] offset;
    assign offset   = PTR_W'(i) - rd_ptr;
    assign match[i] = ({1'b0, offset} < count) && (addr_mem[i] == cmp_addr);
  end

endmodule
`default_nettype wire

// File: rtl/cache_writeback_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_writeback_buffer : write-back buffer with read-after-write hazard drain
// Rev 1.0
// ---------------------------------------------------------------------------
module cache_writeback_buffer
  import cache_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_valid,
  input  logic [ADDR_W-1:0] flush_address,
  input  logic [DATA_W-1:0] flush_data,
  input  logic [MASK_W-1:0] flush_mask,
  output logic              flush_ready,
  input  logic              refill_req,
  input  logic [ADDR_W-1:0] refill_address,
  output logic [DATA_W-1:0] dm_data,
  output logic              refill_valid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [MASK_W-1:0] mem_write_mask,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready,
  output logic              empty,
  output logic              full
);

  state_t            state;
  state_t            state_next;
  logic              refill_pending;
  logic [ADDR_W-1:0] refill_addr_q;
  logic              want_refill;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [MASK_W-1:0] head_mask;
  logic              pop;

  // Once latched, the refill survives refill_req dropping during a drain.
  assign want_refill = refill_pending || refill_req;
  assign cmp_addr    = refill_pending ? refill_addr_q : refill_address;
  assign pop         = (state == ST_WRITE) && mem_ready;
  assign flush_ready = !full;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (flush_valid),
    .push_addr (flush_address),
    .push_data (flush_data),
    .push_mask (flush_mask),
    .pop       (pop),
    .cmp_addr  (cmp_addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_mask (head_mask),
    .match     (match),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (want_refill)  state_next = (|match) ? ST_WRITE : ST_READ;
        else if (!empty)  state_next = ST_WRITE;
      end
      ST_WRITE: if (mem_ready) state_next = ST_IDLE;
      ST_READ:  if (mem_ready) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_address      = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    mem_write_mask   = '0;
    refill_valid     = 1'b0;
    case (state)
      ST_WRITE: begin
        mem_address      = head_addr;
        mem_write_enable = 1'b1;
        mem_write_data   = head_data;
        mem_write_mask   = head_mask;
      end
      ST_READ: begin
        mem_address     = refill_addr_q;
        mem_read_enable = 1'b1;
      end
      ST_RESP:  refill_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refill_pending <= 1'b0;
      refill_addr_q  <= '0;
      dm_data        <= '0;
    end else begin
      if (state == ST_IDLE && refill_req && !refill_pending) begin
        refill_pending <= 1'b1;
        refill_addr_q  <= refill_address;
      end else if (state == ST_RESP) begin
        refill_pending <= 1'b0;
      end
      if (state == ST_READ && mem_ready) dm_data <= mem_read_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_writeback_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_writeback_buffer : directed and random checks against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cache_writeback_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush_valid;
  logic [9:0]  flush_address;
  logic [31:0] flush_data;
  logic [3:0]  flush_mask;
  logic        flush_ready;
  logic        refill_req;
  logic [9:0]  refill_address;
  logic [31:0] dm_data;
  logic        refill_valid;
  logic [9:0]  mem_address;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        empty;
  logic        full;

  cache_writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush_valid      (flush_valid),
    .flush_address    (flush_address),
    .flush_data       (flush_data),
    .flush_mask       (flush_mask),
    .flush_ready      (flush_ready),
    .refill_req       (refill_req),
    .refill_address   (refill_address),
    .dm_data          (dm_data),
    .refill_valid     (refill_valid),
    .mem_address      (mem_address),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_write_mask   (mem_write_mask),
    .mem_read_data    (mem_read_data),
    .mem_ready        (mem_ready),
    .empty            (empty),
    .full             (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t        q[$];
  logic [31:0] committed [1024];
  logic [31:0] phys [1024];
  bit          phys_ready = 1'b0;
  bit          model_init = 1'b0;
  bit          mon_en     = 1'b0;
  bit          got_refill = 1'b0;
  int          refill_out = 0;
  logic [31:0] exp_refill = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [9:0] a);
    return {a, 22'h2B3C1};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Architectural view: committed memory plus every still-buffered write, oldest first.
  function automatic logic [31:0] refill_expect(input logic [9:0] a);
    logic [31:0] v = committed[a];
    foreach (q[i]) if (q[i].a == a) v = merge(v, q[i].d, q[i].m);
    return v;
  endfunction

  function automatic logic [9:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 10'h015;
      1:       return 10'h035;
      2:       return 10'h055;
      default: return 10'h2A0;
    endcase
  endfunction

  // Data memory: byte-masked writes on the edge, read data presented mid-cycle.
  always @(posedge clk) begin
    if (!phys_ready) begin
      for (int i = 0; i < 1024; i++) phys[i] <= init_val(10'(i));
      phys_ready <= 1'b1;
    end else if (mem_write_enable && mem_ready) begin
      phys[mem_address] <= merge(phys[mem_address], mem_write_data, mem_write_mask);
    end
  end

  always @(negedge clk) mem_read_data = phys[mem_address];

  // Reference model: decides at mid-cycle what the coming edge must do.
  always @(negedge clk) begin
    bit acc;
    if (!model_init) begin
      for (int i = 0; i < 1024; i++) committed[i] = init_val(10'(i));
      model_init = 1'b1;
    end
    if (mon_en) begin
      check("strobe_excl", 32'(mem_read_enable && mem_write_enable), 32'd0);
      check("empty_flag", 32'(empty), 32'(q.size() == 0));
      check("full_flag", 32'(full), 32'(q.size() == DEPTH));
      check("flush_ready", 32'(flush_ready), 32'(q.size() < DEPTH));
      acc = flush_valid && (q.size() < DEPTH);
      if (refill_valid) begin
        check("refill_outstanding", 32'(refill_out), 32'd1);
        check("refill_data", dm_data, exp_refill);
        refill_out = 0;
        got_refill = 1'b1;
      end
      if (mem_write_enable && mem_ready) begin
        check("wr_queue_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          check("wr_addr", 32'(mem_address), 32'(q[0].a));
          check("wr_data", mem_write_data, q[0].d);
          check("wr_mask", 32'(mem_write_mask), 32'(q[0].m));
          committed[q[0].a] = merge(committed[q[0].a], q[0].d, q[0].m);
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back('{a: flush_address, d: flush_data, m: flush_mask});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_one(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    flush_valid = 1'b1; flush_address = a; flush_data = d; flush_mask = m;
    next_cycle();
    flush_valid = 1'b0;
  endtask

  task automatic start_refill(input logic [9:0] a);
    refill_address = a;
    refill_req     = 1'b1;
    exp_refill     = refill_expect(a);
    refill_out     = 1;
    got_refill     = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin next_cycle(); n++; end
    check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) next_cycle();
  endtask

  // Records the first write and read strobe cycles; refill_req is pulsed for one cycle.
  task automatic run_order(output int we_c, output int re_c);
    int c = 0;
    we_c = -1;
    re_c = -1;
    while (!(got_refill && q.size() == 0) && c < 60) begin
      @(negedge clk);
      if (mem_write_enable && we_c < 0) we_c = c;
      if (mem_read_enable && re_c < 0) re_c = c;
      next_cycle();
      refill_req = 1'b0;
      c++;
    end
    check("order_timeout", 32'(c < 60), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_c, re_c, n, k;
    reset = 1'b1; flush_valid = 1'b0; flush_address = '0; flush_data = '0; flush_mask = '0;
    refill_req = 1'b0; refill_address = '0; mem_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_flush_ready", 32'(flush_ready), 32'd1);
    check("rst_refill_valid", 32'(refill_valid), 32'd0);
    check("rst_dm_data", dm_data, 32'd0);
    check("rst_mem_re", 32'(mem_read_enable), 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    check("rst_mem_wmask", 32'(mem_write_mask), 32'd0);
    next_cycle();
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) next_cycle();

    // Refill with empty buffer: read strobe in cycle 2, refill_valid in cycle 3.
    flush_one(10'h035, 32'hCAFEBABE, 4'hF);
    drain();
    start_refill(10'h035);
    @(negedge clk);
    check("miss_c1_re", 32'(mem_read_enable), 32'd0);
    next_cycle();
    refill_req = 1'b0;
    @(negedge clk);
    check("miss_c2_re", 32'(mem_read_enable), 32'd1);
    check("miss_c2_addr", 32'(mem_address), 32'h035);
    next_cycle();
    @(negedge clk);
    check("miss_c3_valid", 32'(refill_valid), 32'd1);
    check("miss_c3_data", dm_data, 32'hCAFEBABE);
    next_cycle();
    @(negedge clk);
    check("miss_c4_valid", 32'(refill_valid), 32'd0);
    next_cycle();

    // Refill hitting a buffered write: write must reach memory before the read.
    flush_one(10'h015, 32'h12ADBEEF, 4'hF);
    start_refill(10'h015);
    run_order(we_c, re_c);
    check("raw_order", 32'(we_c >= 0 && re_c > we_c), 32'd1);
    check("raw_data", dm_data, 32'h12ADBEEF);
    repeat (2) next_cycle();

    // Single write-back: strobe two cycles after the flush, then empty.
    flush_one(10'h015, 32'h12ADBEEF, 4'hF);
    @(negedge clk);
    check("wb_c1_we", 32'(mem_write_enable), 32'd0);
    check("wb_c1_empty", 32'(empty), 32'd0);
    next_cycle();
    @(negedge clk);
    check("wb_c2_we", 32'(mem_write_enable), 32'd1);
    check("wb_c2_addr", 32'(mem_address), 32'h015);
    check("wb_c2_data", mem_write_data, 32'h12ADBEEF);
    check("wb_c2_mask", 32'(mem_write_mask), 32'hF);
    next_cycle();
    @(negedge clk);
    check("wb_c3_empty", 32'(empty), 32'd1);
    check("wb_c3_we", 32'(mem_write_enable), 32'd0);
    next_cycle();

    // Fill with memory stalled, offer a fifth entry, then release.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush_valid = 1'b1; flush_address = 10'h100 + 10'(i);
      flush_data = $urandom; flush_mask = 4'($urandom_range(1, 15));
      next_cycle();
    end
    flush_address = 10'h1FF; flush_data = 32'h5555AAAA; flush_mask = 4'hF;
    @(negedge clk);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ready", 32'(flush_ready), 32'd0);
    next_cycle();
    flush_valid = 1'b0;
    mem_ready   = 1'b1;
    @(negedge clk);
    check("deq_ready_same", 32'(flush_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check("deq_ready_next", 32'(flush_ready), 32'd1);
    drain();

    // Non-matching refill overtakes a buffered write.
    flush_one(10'h055, $urandom, 4'hF);
    start_refill(10'h035);
    run_order(we_c, re_c);
    check("read_first", 32'(re_c >= 0 && we_c > re_c), 32'd1);
    repeat (2) next_cycle();

    // Reset in the middle of a stalled write with two entries buffered.
    mem_ready = 1'b0;
    flush_valid = 1'b1; flush_address = 10'h0AA; flush_data = 32'h11111111; flush_mask = 4'hF;
    next_cycle();
    flush_address = 10'h0BB; flush_data = 32'h22222222;
    next_cycle();
    flush_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_we", 32'(mem_write_enable), 32'd1);
    next_cycle();
    reset = 1'b1; mon_en = 1'b0; q.delete(); refill_out = 0;
    @(negedge clk);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_we", 32'(mem_write_enable), 32'd0);
    check("mid_rst_re", 32'(mem_read_enable), 32'd0);
    check("mid_rst_rv", 32'(refill_valid), 32'd0);
    next_cycle();
    reset = 1'b0; mem_ready = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_we", 32'(mem_write_enable), 32'd0);
      next_cycle();
    end

    // Random bursts of flushes and held refills with a stalling memory.
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 6);
      for (int j = 0; j < k; j++) begin
        flush_valid   = ($urandom_range(0, 3) != 0);
        flush_address = pick_addr();
        flush_data    = $urandom;
        flush_mask    = 4'($urandom_range(0, 15));
        mem_ready     = ($urandom_range(0, 3) != 0);
        next_cycle();
      end
      flush_valid = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        start_refill(pick_addr());
        n = 0;
        while (!got_refill && n < 300) begin
          mem_ready = ($urandom_range(0, 2) != 0);
          next_cycle();
          n++;
        end
        check("rand_refill_timeout", 32'(got_refill), 32'd1);
        refill_req = 1'b0;
      end
    end
    mem_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
